ledpanel_frame_writer: RTL and testbench

LEDPANEL_FRAME_WRITER -- requirements
Module: ledpanel_frame_writer

---
 rtl/ledpanel_frame_writer.sv | 146 ++++++++++++++
 tb/tb_ledpanel_frame_writer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ledpanel_frame_writer.sv
// Streams RGB888 pixels into LED panel frame memory as {y, x} addressed writes,
// with start-of-frame sync, mid-frame resync and a whole-memory clear sweep.
module ledpanel_frame_writer #(
  parameter int CHAINED     = 1,
  parameter int INPUT_DEPTH = 6
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        clear_req,
  output logic        ctrl_en,
  output logic [15:0] ctrl_addr,
  output logic [23:0] ctrl_wdat,
  output logic        busy,
  output logic        frame_done,
  output logic        sof_err,
  output logic [7:0]  frame_cnt
);

  localparam int W  = 64 * CHAINED;
  localparam int XW = 6 + $clog2(CHAINED);
  localparam int AW = XW + 6;
  localparam int N  = W * 64;
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);

  typedef enum logic [1:0] {SYNC, STREAM, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] x, x_nxt;
  logic [5:0]    y, y_nxt;
  logic [AW-1:0] clr_cnt, clr_nxt;
  logic          accept;
  logic          wr_en_p0, clr_p0, done_p0, err_p0;
  logic [AW-1:0] addr_p0;
  logic [23:0]   dat_p0;

  // Keep the INPUT_DEPTH MSBs of each channel, right-aligned in its byte.
  function automatic logic [23:0] scale_rgb(input logic [23:0] d);
    logic [23:0] r;
    for (int i = 0; i < 3; i++) r[8*i +: 8] = d[8*i +: 8] >> (8 - INPUT_DEPTH);
    return r;
  endfunction

  assign s_ready = (state != CLEAR) && !clear_req;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    clr_nxt   = clr_cnt;
    wr_en_p0  = 1'b0;
    clr_p0    = 1'b0;
    done_p0   = 1'b0;
    err_p0    = 1'b0;
    addr_p0   = '0;
    dat_p0    = scale_rgb(s_data);
    case (state)
      SYNC, STREAM: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          clr_nxt   = '0;
          x_nxt     = '0;
          y_nxt     = '0;
        end else if (accept && s_sof) begin
          // A start-of-frame always restarts at the origin; mid-frame it is flagged.
          wr_en_p0  = 1'b1;
          err_p0    = (state == STREAM);
          x_nxt     = XW'(1);
          y_nxt     = '0;
          state_nxt = STREAM;
        end else if (accept && state == STREAM) begin
          wr_en_p0 = 1'b1;
          addr_p0  = {y, x};
          if (x == X_LAST) begin
            x_nxt = '0;
            if (y == 6'd63) begin
              done_p0   = 1'b1;
              y_nxt     = '0;
              state_nxt = SYNC;
            end else begin
              y_nxt = y + 6'd1;
            end
          end else begin
            x_nxt = x + 1'b1;
          end
        end
      end
      CLEAR: begin
        wr_en_p0 = 1'b1;
        clr_p0   = 1'b1;
        addr_p0  = clr_cnt;
        dat_p0   = '0;
        if (clr_cnt == A_LAST) begin
          clr_nxt   = '0;
          state_nxt = SYNC;
        end else begin
          clr_nxt = clr_cnt + 1'b1;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state   <= SYNC;
      x       <= '0;
      y       <= '0;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      clr_cnt <= clr_nxt;
    end
  end

  // p0 -> p1: registered memory write port and status pulses
  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      ctrl_en    <= 1'b0;
      ctrl_addr  <= '0;
      ctrl_wdat  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      ctrl_en    <= wr_en_p0;
      busy       <= clr_p0;
      frame_done <= done_p0;
      sof_err    <= err_p0;
      if (wr_en_p0) begin
        ctrl_addr <= 16'(addr_p0);
        ctrl_wdat <= dat_p0;
      end
      if (done_p0) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ledpanel_frame_writer.sv
// Bench for ledpanel_frame_writer: random pixel streams against a pixel-index
// reference model, plus clear, resync and reset-abort scenarios.
module tb_ledpanel_frame_writer;

  localparam int CHAINED     = 1;
  localparam int INPUT_DEPTH = 6;
  localparam int W           = 64 * CHAINED;
  localparam int H           = 64;
  localparam int N           = W * H;
  localparam int XW          = 6;

  logic        ctrl_clk   = 1'b0;
  logic        ctrl_rst_n = 1'b1;
  logic        s_valid    = 1'b0;
  logic        s_sof      = 1'b0;
  logic        clear_req  = 1'b0;
  logic [23:0] s_data     = '0;
  logic        s_ready, ctrl_en, busy, frame_done, sof_err;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic [7:0]  frame_cnt;

  ledpanel_frame_writer #(.CHAINED(CHAINED), .INPUT_DEPTH(INPUT_DEPTH)) dut (
    .ctrl_clk(ctrl_clk), .ctrl_rst_n(ctrl_rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .clear_req(clear_req), .ctrl_en(ctrl_en),
    .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat), .busy(busy), .frame_done(frame_done),
    .sof_err(sof_err), .frame_cnt(frame_cnt)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] addr;
    logic [23:0] dat;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  obs_base;
  int  busy_cycles, done_cycles, err_cycles;
  int  n_assert, n_fail;
  bit  m_in_frame;
  int  m_idx, m_frames;

  always @(negedge ctrl_clk) begin
    if (ctrl_en) obs_q.push_back({busy, frame_done, sof_err, ctrl_addr, ctrl_wdat});
    if (busy) busy_cycles <= busy_cycles + 1;
    if (frame_done) done_cycles <= done_cycles + 1;
    if (sof_err) err_cycles <= err_cycles + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] exp_rgb(input logic [23:0] d);
    logic [23:0] r;
    int div;
    div = 1 << (8 - INPUT_DEPTH);
    r = '0;
    for (int i = 0; i < 3; i++) r[8*i +: 8] = 8'(32'(d[8*i +: 8]) / div);
    return r;
  endfunction

  function automatic logic [15:0] exp_addr(input int idx);
    return 16'((idx / W) * (1 << XW) + (idx % W));
  endfunction

  // Reference: a frame is a run of N pixel indices starting at a sof pixel.
  function automatic void model_pixel(input logic [23:0] d, input logic sof);
    logic last;
    if (sof) begin
      exp_q.push_back({1'b0, 1'b0, m_in_frame, 16'h0000, exp_rgb(d)});
      m_in_frame = 1'b1;
      m_idx      = 1;
    end else if (m_in_frame) begin
      last = (m_idx == N - 1);
      exp_q.push_back({1'b0, last, 1'b0, exp_addr(m_idx), exp_rgb(d)});
      if (last) begin
        m_frames++;
        m_in_frame = 1'b0;
        m_idx      = 0;
      end else begin
        m_idx++;
      end
    end
  endfunction

  function automatic void model_clear(input int upto);
    m_in_frame = 1'b0;
    m_idx      = 0;
    for (int a = 0; a < upto; a++) exp_q.push_back({1'b1, 1'b0, 1'b0, 16'(a), 24'h0});
  endfunction

  task automatic pix(input logic v, input logic [23:0] d, input logic sof);
    s_valid = v;
    s_data  = d;
    s_sof   = sof;
    if (v) model_pixel(d, sof);
    @(posedge ctrl_clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic reset_dut();
    s_valid    = 1'b0;
    s_sof      = 1'b0;
    clear_req  = 1'b0;
    ctrl_rst_n = 1'b0;
    #1;
    obs_base   = obs_q.size();
    exp_q.delete();
    m_in_frame = 1'b0;
    m_idx      = 0;
    m_frames   = 0;
    repeat (2) @(posedge ctrl_clk);
    #1;
    ctrl_rst_n = 1'b1;
    @(posedge ctrl_clk);
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    pix(1'b1, 24'hC0FFEE, 1'b1);
    pix(1'b1, 24'h8899AA, 1'b0);
    #3;
    ctrl_rst_n = 1'b0;
    #1;
    n_assert++;
    if ({ctrl_en, busy, frame_done, sof_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000", {ctrl_en, busy, frame_done, sof_err});
    end
    n_assert++;
    if (ctrl_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_addr: got %h required 0000", ctrl_addr);
    end
    n_assert++;
    if (ctrl_wdat !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_wdat: got %h required 000000", ctrl_wdat);
    end
    n_assert++;
    if (frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
    end
    n_assert++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 1", s_ready);
    end
    reset_dut();
  endtask

  task automatic test_sync_drop();
    int base;
    reset_dut();
    base = obs_base;
    for (int i = 0; i < 3; i++) pix(1'b1, 24'($urandom), 1'b0);
    pix(1'b1, 24'hFF8004, 1'b1);
    pix(1'b0, 24'h0, 1'b0);
    pix(1'b0, 24'h0, 1'b0);
    n_assert++;
    if (obs_q.size() - base !== 1) begin
      n_fail++;
      $display("FAIL sync_drop_count: got %0d writes required 1", obs_q.size() - base);
    end else begin
      n_assert++;
      if (obs_q[base].addr !== 16'h0000 || obs_q[base].dat !== 24'h3F2001) begin
        n_fail++;
        $display("FAIL sync_first_write: got addr %h wdat %h required 0000 3F2001",
                 obs_q[base].addr, obs_q[base].dat);
      end
    end
  endtask

  task automatic test_full_frame();
    int bad, first, d0;
    reset_dut();
    d0 = done_cycles;
    for (int i = 0; i < N; i++) pix(1'b1, 24'($urandom), (i == 0));
    pix(1'b1, 24'($urandom), 1'b0);
    pix(1'b0, 24'h0, 1'b0);
    pix(1'b0, 24'h0, 1'b0);
    bad = 0; first = -1;
    if (obs_q.size() - obs_base != exp_q.size()) bad = 1;
    for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++)
      if (obs_q[obs_base + i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      if (first >= 0) $display("FAIL full_frame_seq: write %0d got %h required %h", first, obs_q[obs_base + first], exp_q[first]);
      else $display("FAIL full_frame_seq: got %0d writes required %0d", obs_q.size() - obs_base, exp_q.size());
    end
    n_assert++;
    if (frame_cnt !== 8'(m_frames)) begin
      n_fail++;
      $display("FAIL full_frame_cnt: got %0d required %0d", frame_cnt, m_frames);
    end
    n_assert++;
    if (done_cycles - d0 !== 1) begin
      n_fail++;
      $display("FAIL full_frame_done_pulses: got %0d required 1", done_cycles - d0);
    end
  endtask

  task automatic test_sof_err();
    int bad, first, e0;
    reset_dut();
    e0 = err_cycles;
    for (int i = 0; i < 100; i++) pix(1'b1, 24'($urandom), (i == 0));
    pix(1'b1, 24'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) pix(1'b1, 24'($urandom), 1'b0);
    pix(1'b0, 24'h0, 1'b0);
    pix(1'b0, 24'h0, 1'b0);
    bad = 0; first = -1;
    if (obs_q.size() - obs_base != exp_q.size()) bad = 1;
    for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++)
      if (obs_q[obs_base + i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      if (first >= 0) $display("FAIL sof_err_seq: write %0d got %h required %h", first, obs_q[obs_base + first], exp_q[first]);
      else $display("FAIL sof_err_seq: got %0d writes required %0d", obs_q.size() - obs_base, exp_q.size());
    end
    n_assert++;
    if (err_cycles - e0 !== 1) begin
      n_fail++;
      $display("FAIL sof_err_pulses: got %0d required 1", err_cycles - e0);
    end
    n_assert++;
    if (frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL sof_err_frame_cnt: got %0d required 0", frame_cnt);
    end
  endtask

  task automatic test_clear();
    int bad, first, b0;
    reset_dut();
    for (int i = 0; i < 10; i++) pix(1'b1, 24'($urandom), (i == 0));
    s_valid   = 1'b1;
    s_data    = 24'($urandom);
    clear_req = 1'b1;
    #1;
    n_assert++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_req_ready: got %b required 0", s_ready);
    end
    b0 = busy_cycles;
    model_clear(N);
    @(posedge ctrl_clk);
    #1;
    for (int c = 0; c < N + 4; c++) begin
      s_valid   = 1'b1;
      s_data    = 24'($urandom);
      clear_req = (c == 2000);
      if (c == 1000) begin
        n_assert++;
        if (s_ready !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL clear_mid: got ready %b busy %b required 0 1", s_ready, busy);
        end
      end
      @(posedge ctrl_clk);
      #1;
    end
    s_valid   = 1'b0;
    clear_req = 1'b0;
    #1;
    n_assert++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_done_ready: got %b required 1", s_ready);
    end
    n_assert++;
    if (busy_cycles - b0 !== N) begin
      n_fail++;
      $display("FAIL clear_busy_cycles: got %0d required %0d", busy_cycles - b0, N);
    end
    pix(1'b1, 24'($urandom), 1'b0);
    pix(1'b1, 24'($urandom), 1'b1);
    pix(1'b0, 24'h0, 1'b0);
    pix(1'b0, 24'h0, 1'b0);
    bad = 0; first = -1;
    if (obs_q.size() - obs_base != exp_q.size()) bad = 1;
    for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++)
      if (obs_q[obs_base + i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      if (first >= 0) $display("FAIL clear_seq: write %0d got %h required %h", first, obs_q[obs_base + first], exp_q[first]);
      else $display("FAIL clear_seq: got %0d writes required %0d", obs_q.size() - obs_base, exp_q.size());
    end
  endtask

  task automatic test_reset_in_clear();
    int bad, first;
    bit found;
    reset_dut();
    clear_req = 1'b1;
    @(posedge ctrl_clk);
    #1;
    clear_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 5000 && !found; c++) begin
      if (ctrl_en === 1'b1 && ctrl_addr === 16'h0800) found = 1'b1;
      else begin
        @(posedge ctrl_clk);
        #1;
      end
    end
    ctrl_rst_n = 1'b0;
    #1;
    n_assert++;
    if (!found) begin
      n_fail++;
      $display("FAIL clear_reach_800: got no write to 0800 required one within 5000 cycles");
    end
    n_assert++;
    if (ctrl_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: got en %b busy %b required 0 0", ctrl_en, busy);
    end
    model_clear(16'h0800);
    repeat (2) @(posedge ctrl_clk);
    #1;
    ctrl_rst_n = 1'b1;
    @(posedge ctrl_clk);
    #1;
    for (int i = 0; i < 4; i++) pix(1'b1, 24'($urandom), 1'b0);
    pix(1'b1, 24'($urandom), 1'b1);
    pix(1'b0, 24'h0, 1'b0);
    pix(1'b0, 24'h0, 1'b0);
    bad = 0; first = -1;
    if (obs_q.size() - obs_base != exp_q.size()) bad = 1;
    for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++)
      if (obs_q[obs_base + i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      if (first >= 0) $display("FAIL reset_clear_seq: write %0d got %h required %h", first, obs_q[obs_base + first], exp_q[first]);
      else $display("FAIL reset_clear_seq: got %0d writes required %0d", obs_q.size() - obs_base, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int bad, first, d0;
    reset_dut();
    d0 = done_cycles;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N; i++) begin
        while ($urandom_range(0, 3) == 0) pix(1'b0, 24'($urandom), 1'b0);
        pix(1'b1, 24'($urandom), (i == 0));
      end
    pix(1'b0, 24'h0, 1'b0);
    pix(1'b0, 24'h0, 1'b0);
    bad = 0; first = -1;
    if (obs_q.size() - obs_base != exp_q.size()) bad = 1;
    for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++)
      if (obs_q[obs_base + i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      if (first >= 0) $display("FAIL gaps_seq: write %0d got %h required %h", first, obs_q[obs_base + first], exp_q[first]);
      else $display("FAIL gaps_seq: got %0d writes required %0d", obs_q.size() - obs_base, exp_q.size());
    end
    n_assert++;
    if (frame_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL gaps_frame_cnt: got %0d required 2", frame_cnt);
    end
    n_assert++;
    if (done_cycles - d0 !== 2) begin
      n_fail++;
      $display("FAIL gaps_done_pulses: got %0d required 2", done_cycles - d0);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_sync_drop();
    test_full_frame();
    test_sof_err();
    test_clear();
    test_reset_in_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
